alu_issue_stage: RTL and testbench

//  Producer side of the ALU operand interface (DATA1, DATA2, ALU_OPERATION).

---
 rtl/alu_issue_stage_pkg.sv | 51 +++++
 rtl/alu_op_decode.sv | 76 +++++++
 rtl/alu_issue_stage.sv | 116 +++++++++++
 tb/tb_alu_issue_stage.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// rtl/alu_issue_stage_pkg.sv - ALU op codes, RV opcodes and operand selects for the ALU issue stage
package alu_issue_stage_pkg;

    localparam logic [4:0] ALU_AND    = 5'b00000;
    localparam logic [4:0] ALU_OR     = 5'b00001;
    localparam logic [4:0] ALU_ADD    = 5'b00010;
    localparam logic [4:0] ALU_SUB    = 5'b00011;
    localparam logic [4:0] ALU_SLL    = 5'b00100;
    localparam logic [4:0] ALU_SLT    = 5'b00101;
    localparam logic [4:0] ALU_SLTU   = 5'b00110;
    localparam logic [4:0] ALU_XOR    = 5'b00111;
    localparam logic [4:0] ALU_SRL    = 5'b01000;
    localparam logic [4:0] ALU_SRA    = 5'b01001;
    localparam logic [4:0] ALU_MUL    = 5'b01010;
    localparam logic [4:0] ALU_MULH   = 5'b01011;
    localparam logic [4:0] ALU_MULHSU = 5'b01100;
    localparam logic [4:0] ALU_MULHU  = 5'b01101;
    localparam logic [4:0] ALU_DIV    = 5'b01110;
    localparam logic [4:0] ALU_DIVU   = 5'b01111;
    localparam logic [4:0] ALU_REM    = 5'b10000;
    localparam logic [4:0] ALU_REMU   = 5'b10001;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef enum logic [1:0] {SEL1_ZERO, SEL1_RS1, SEL1_PC}  sel1_e;
    typedef enum logic [1:0] {SEL2_ZERO, SEL2_RS2, SEL2_IMM} sel2_e;

    // funct7 = 0 register/immediate forms share this funct3 mapping
    function automatic logic [4:0] base_op(input logic [2:0] funct3);
        case (funct3)
            3'b000:  base_op = ALU_ADD;
            3'b001:  base_op = ALU_SLL;
            3'b010:  base_op = ALU_SLT;
            3'b011:  base_op = ALU_SLTU;
            3'b100:  base_op = ALU_XOR;
            3'b101:  base_op = ALU_SRL;
            3'b110:  base_op = ALU_OR;
            default: base_op = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - opcode/funct to {op, sel1, sel2, illegal}; M extension when ALU_ISSUE_MEXT_EN is defined
module alu_op_decode
    import alu_issue_stage_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [4:0] op,
    output sel1_e      sel1,
    output sel2_e      sel2,
    output logic       illegal
);

    always_comb begin
        op      = ALU_ADD;
        sel1    = SEL1_ZERO;
        sel2    = SEL2_ZERO;
        illegal = 1'b1;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    op      = base_op(funct3);
                    illegal = 1'b0;
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    op      = ALU_SUB;
                    illegal = 1'b0;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    op      = ALU_SRA;
                    illegal = 1'b0;
                end
`ifdef ALU_ISSUE_MEXT_EN
                else if (funct7 == F7_MEXT) begin
                    op      = ALU_MUL + {2'b00, funct3};
                    illegal = 1'b0;
                end
`endif
                if (!illegal) begin
                    sel1 = SEL1_RS1;
                    sel2 = SEL2_RS2;
                end
            end
            OPC_OPIMM: begin
                illegal = 1'b0;
                case (funct3)
                    3'b001: begin
                        if (funct7 == F7_BASE) op = ALU_SLL;
                        else                   illegal = 1'b1;
                    end
                    3'b101:  op = funct7[5] ? ALU_SRA : ALU_SRL;
                    default: op = base_op(funct3);
                endcase
                if (!illegal) begin
                    sel1 = SEL1_RS1;
                    sel2 = SEL2_IMM;
                end
            end
            OPC_LUI: begin
                sel2    = SEL2_IMM;
                illegal = 1'b0;
            end
            OPC_AUIPC: begin
                sel1    = SEL1_PC;
                sel2    = SEL2_IMM;
                illegal = 1'b0;
            end
            OPC_LOAD, OPC_STORE: begin
                sel1    = SEL1_RS1;
                sel2    = SEL2_IMM;
                illegal = 1'b0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ID/EX issue register with 2-entry skid buffer; M decode gated by ALU_ISSUE_MEXT_EN
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OPW  = 5
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            FLUSH,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [6:0]      OPCODE,
    input  logic [2:0]      FUNCT3,
    input  logic [6:0]      FUNCT7,
    input  logic [XLEN-1:0] PC,
    input  logic [XLEN-1:0] RS1_DATA,
    input  logic [XLEN-1:0] RS2_DATA,
    input  logic [XLEN-1:0] IMM,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [XLEN-1:0] DATA1,
    output logic [XLEN-1:0] DATA2,
    output logic [OPW-1:0]  ALU_OPERATION,
    output logic            ILLEGAL
);

    logic [OPW-1:0]  dec_op;
    sel1_e           dec_sel1;
    sel2_e           dec_sel2;
    logic            dec_illegal;
    logic [XLEN-1:0] new_d1, new_d2;

    logic            main_v, skid_v;
    logic [XLEN-1:0] main_d1, main_d2, skid_d1, skid_d2;
    logic [OPW-1:0]  main_op, skid_op;
    logic            main_ill, skid_ill;
    logic            accept, drain;

    alu_op_decode u_decode (
        .opcode  (OPCODE),
        .funct3  (FUNCT3),
        .funct7  (FUNCT7),
        .op      (dec_op),
        .sel1    (dec_sel1),
        .sel2    (dec_sel2),
        .illegal (dec_illegal)
    );

    always_comb begin
        case (dec_sel1)
            SEL1_RS1: new_d1 = RS1_DATA;
            SEL1_PC:  new_d1 = PC;
            default:  new_d1 = '0;
        endcase
        case (dec_sel2)
            SEL2_RS2: new_d2 = RS2_DATA;
            SEL2_IMM: new_d2 = IMM;
            default:  new_d2 = '0;
        endcase
    end

    // Skid occupancy alone throttles the producer, so IN_READY is a pure flop output
    assign IN_READY = ~skid_v;
    assign accept   = IN_VALID & IN_READY;
    assign drain    = main_v & OUT_READY;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            main_v   <= 1'b0;
            skid_v   <= 1'b0;
            main_d1  <= '0;
            main_d2  <= '0;
            main_op  <= '0;
            main_ill <= 1'b0;
            skid_d1  <= '0;
            skid_d2  <= '0;
            skid_op  <= '0;
            skid_ill <= 1'b0;
        end else if (FLUSH) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (skid_v) begin
            if (drain) begin
                main_d1  <= skid_d1;
                main_d2  <= skid_d2;
                main_op  <= skid_op;
                main_ill <= skid_ill;
                skid_v   <= 1'b0;
            end
        end else if (accept) begin
            if (!main_v || drain) begin
                main_d1  <= new_d1;
                main_d2  <= new_d2;
                main_op  <= dec_op;
                main_ill <= dec_illegal;
                main_v   <= 1'b1;
            end else begin
                skid_d1  <= new_d1;
                skid_d2  <= new_d2;
                skid_op  <= dec_op;
                skid_ill <= dec_illegal;
                skid_v   <= 1'b1;
            end
        end else if (drain) begin
            main_v <= 1'b0;
        end
    end

    assign OUT_VALID     = main_v;
    assign DATA1         = main_d1;
    assign DATA2         = main_d2;
    assign ALU_OPERATION = main_op;
    assign ILLEGAL       = main_ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - bench for alu_issue_stage; M-extension expectations follow ALU_ISSUE_MEXT_EN
module tb_alu_issue_stage;

    logic        CLK = 1'b0;
    logic        RESET, FLUSH, IN_VALID, IN_READY, OUT_VALID, OUT_READY, ILLEGAL;
    logic [6:0]  OPCODE, FUNCT7;
    logic [2:0]  FUNCT3;
    logic [31:0] PC, RS1_DATA, RS2_DATA, IMM, DATA1, DATA2;
    logic [4:0]  ALU_OPERATION;

    alu_issue_stage #(.XLEN(32), .OPW(5)) dut (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OPCODE(OPCODE), .FUNCT3(FUNCT3), .FUNCT7(FUNCT7), .PC(PC),
        .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA), .IMM(IMM),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .DATA1(DATA1), .DATA2(DATA2),
        .ALU_OPERATION(ALU_OPERATION), .ILLEGAL(ILLEGAL)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        ill;
    } exp_t;

    // funct3 -> mnemonic table, 5 bits per slot, slot 0 at the bottom: ADD SLL SLT SLTU XOR SRL OR AND
    localparam logic [39:0] BASE_TBL = {5'd0, 5'd1, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd2};

    function automatic exp_t expect_of(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                       input logic [31:0] pc, input logic [31:0] rs1,
                                       input logic [31:0] rs2, input logic [31:0] imm);
        exp_t e;
        bit   ok;
        ok = 1'b1;
        e  = '{op: 5'd2, d1: 32'h0, d2: 32'h0, ill: 1'b0};
        if (opc == 7'h33) begin
            e.d1 = rs1;
            e.d2 = rs2;
            if (f7 == 7'h00)                     e.op = BASE_TBL[int'(f3)*5 +: 5];
            else if (f7 == 7'h20 && f3 == 3'd0)  e.op = 5'd3;
            else if (f7 == 7'h20 && f3 == 3'd5)  e.op = 5'd9;
`ifdef ALU_ISSUE_MEXT_EN
            else if (f7 == 7'h01)                e.op = 5'd10 + 5'(f3);
`endif
            else                                 ok = 1'b0;
        end else if (opc == 7'h13) begin
            e.d1 = rs1;
            e.d2 = imm;
            if (f3 == 3'd1 && f7 != 7'h00) ok = 1'b0;
            else if (f3 == 3'd5)           e.op = f7[5] ? 5'd9 : 5'd8;
            else                           e.op = BASE_TBL[int'(f3)*5 +: 5];
        end else if (opc == 7'h37) begin
            e.d2 = imm;
        end else if (opc == 7'h17) begin
            e.d1 = pc;
            e.d2 = imm;
        end else if (opc == 7'h03 || opc == 7'h23) begin
            e.d1 = rs1;
            e.d2 = imm;
        end else begin
            ok = 1'b0;
        end
        if (!ok) e = '{op: 5'd2, d1: 32'h0, d2: 32'h0, ill: 1'b1};
        return e;
    endfunction

    // Model: in-order queue of at most two entries; head is what the ALU must see
    exp_t q[$];
    bit   acc_flag;
    bit   check_en = 1'b0;
    int   mn;

    always @(posedge CLK) begin
        acc_flag = 1'b0;
        if (RESET === 1'b1 || FLUSH === 1'b1) begin
            q.delete();
        end else begin
            mn = q.size();
            if (mn > 0 && OUT_READY === 1'b1) void'(q.pop_front());
            if (IN_VALID === 1'b1 && mn < 2) begin
                q.push_back(expect_of(OPCODE, FUNCT3, FUNCT7, PC, RS1_DATA, RS2_DATA, IMM));
                acc_flag = 1'b1;
            end
        end
    end

    always @(negedge CLK) begin
        if (check_en) begin
            chk("cmp_out_valid", 32'(OUT_VALID), 32'(q.size() > 0));
            chk("cmp_in_ready", 32'(IN_READY), 32'(q.size() < 2));
            if (q.size() > 0) begin
                chk("cmp_data1", DATA1, q[0].d1);
                chk("cmp_data2", DATA2, q[0].d2);
                chk("cmp_op", 32'(ALU_OPERATION), 32'(q[0].op));
                chk("cmp_illegal", 32'(ILLEGAL), 32'(q[0].ill));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic put(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
        OPCODE   = opc;
        FUNCT3   = f3;
        FUNCT7   = f7;
        RS1_DATA = rs1;
        RS2_DATA = rs2;
        IMM      = imm;
        IN_VALID = 1'b1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_out_valid"}, 32'(OUT_VALID), 32'd0);
        chk({tag, "_in_ready"}, 32'(IN_READY), 32'd1);
        chk({tag, "_data1"}, DATA1, 32'd0);
        chk({tag, "_data2"}, DATA2, 32'd0);
        chk({tag, "_op"}, 32'(ALU_OPERATION), 32'd0);
        chk({tag, "_illegal"}, 32'(ILLEGAL), 32'd0);
    endtask

    typedef struct packed {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } vec_t;

    vec_t vecs [0:17];
    int   cyc;

    initial begin
        RESET = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        OPCODE = '0; FUNCT3 = '0; FUNCT7 = '0; PC = 32'h0000_1000;
        RS1_DATA = '0; RS2_DATA = '0; IMM = '0;
        vecs = '{
            '{7'h33, 3'd6, 7'h00, 32'h0}, '{7'h33, 3'd4, 7'h00, 32'h0},
            '{7'h33, 3'd2, 7'h00, 32'h0}, '{7'h33, 3'd3, 7'h00, 32'h0},
            '{7'h33, 3'd1, 7'h00, 32'h0}, '{7'h33, 3'd5, 7'h00, 32'h0},
            '{7'h33, 3'd7, 7'h00, 32'h0}, '{7'h33, 3'd1, 7'h20, 32'h0},
            '{7'h13, 3'd7, 7'h00, 32'hff}, '{7'h13, 3'd2, 7'h7f, 32'hffff_fff0},
            '{7'h13, 3'd1, 7'h00, 32'h3}, '{7'h13, 3'd1, 7'h20, 32'h3},
            '{7'h13, 3'd5, 7'h00, 32'h4}, '{7'h17, 3'd0, 7'h00, 32'h2000},
            '{7'h03, 3'd2, 7'h00, 32'h8}, '{7'h23, 3'd2, 7'h00, 32'hffff_fffc},
            '{7'h6f, 3'd0, 7'h00, 32'h10}, '{7'h33, 3'd3, 7'h01, 32'h0}
        };

        tick(); tick();
        @(negedge CLK);
        chk_reset_values("reset");
        check_en = 1'b1;
        tick();
        RESET = 1'b0;

        // single ADD, then SUB and SRAI
        OUT_READY = 1'b1;
        put(7'h33, 3'd0, 7'h00, 32'h10, 32'h20, 32'h0);
        tick(); IN_VALID = 1'b0;
        @(negedge CLK);
        chk("add_valid", 32'(OUT_VALID), 32'd1);
        chk("add_data1", DATA1, 32'h10);
        chk("add_data2", DATA2, 32'h20);
        chk("add_op", 32'(ALU_OPERATION), 32'b00010);
        put(7'h33, 3'd0, 7'h20, 32'h5, 32'h3, 32'h0);
        tick(); IN_VALID = 1'b0;
        @(negedge CLK);
        chk("sub_op", 32'(ALU_OPERATION), 32'b00011);
        put(7'h13, 3'd5, 7'h20, 32'h8000_0000, 32'h77, 32'h1);
        tick(); IN_VALID = 1'b0;
        @(negedge CLK);
        chk("srai_op", 32'(ALU_OPERATION), 32'b01001);
        chk("srai_data1", DATA1, 32'h8000_0000);
        chk("srai_data2", DATA2, 32'h1);

        // back-to-back at full throughput
        put(7'h33, 3'd0, 7'h00, 32'hA1, 32'h1, 32'h0);
        tick();
        put(7'h33, 3'd0, 7'h00, 32'hA2, 32'h2, 32'h0);
        tick(); IN_VALID = 1'b0;
        @(negedge CLK);
        chk("thru_data1", DATA1, 32'hA2);
        chk("thru_valid", 32'(OUT_VALID), 32'd1);

        // stall: A, B held, C waits, then released in order
        tick();
        OUT_READY = 1'b0;
        put(7'h33, 3'd0, 7'h00, 32'h1, 32'h0, 32'h0);
        tick();
        put(7'h33, 3'd0, 7'h00, 32'h2, 32'h0, 32'h0);
        tick();
        put(7'h33, 3'd0, 7'h00, 32'h3, 32'h0, 32'h0);
        @(negedge CLK);
        chk("stall_in_ready", 32'(IN_READY), 32'd0);
        chk("stall_head", DATA1, 32'h1);
        tick();
        OUT_READY = 1'b1;
        @(negedge CLK);
        chk("release_a", DATA1, 32'h1);
        tick();
        @(negedge CLK);
        chk("release_b", DATA1, 32'h2);
        chk("release_ready", 32'(IN_READY), 32'd1);
        tick(); IN_VALID = 1'b0;
        @(negedge CLK);
        chk("release_c", DATA1, 32'h3);
        tick();
        @(negedge CLK);
        chk("release_empty", 32'(OUT_VALID), 32'd0);

        // flush with both entries held and input offered
        OUT_READY = 1'b0;
        put(7'h33, 3'd0, 7'h00, 32'h11, 32'h0, 32'h0);
        tick();
        put(7'h33, 3'd0, 7'h00, 32'h12, 32'h0, 32'h0);
        tick();
        put(7'h33, 3'd0, 7'h00, 32'h13, 32'h0, 32'h0);
        FLUSH = 1'b1;
        tick(); FLUSH = 1'b0; IN_VALID = 1'b0;
        @(negedge CLK);
        chk("flush_valid", 32'(OUT_VALID), 32'd0);
        chk("flush_ready", 32'(IN_READY), 32'd1);
        OUT_READY = 1'b1;
        repeat (3) tick();
        @(negedge CLK);
        chk("flush_nothing_later", 32'(OUT_VALID), 32'd0);

        // flush while input is accepted: the new entry is discarded too
        OUT_READY = 1'b0;
        put(7'h33, 3'd0, 7'h00, 32'h21, 32'h0, 32'h0);
        tick();
        put(7'h33, 3'd0, 7'h00, 32'h22, 32'h0, 32'h0);
        FLUSH = 1'b1;
        tick(); FLUSH = 1'b0; IN_VALID = 1'b0;
        @(negedge CLK);
        chk("flush_in_valid", 32'(OUT_VALID), 32'd0);
        OUT_READY = 1'b1;
        tick(); tick();

        // M-extension encoding (DIV)
        put(7'h33, 3'd4, 7'h01, 32'h5, 32'h6, 32'h0);
        tick(); IN_VALID = 1'b0;
        @(negedge CLK);
`ifdef ALU_ISSUE_MEXT_EN
        chk("mext_op", 32'(ALU_OPERATION), 32'b01110);
        chk("mext_illegal", 32'(ILLEGAL), 32'd0);
        chk("mext_data1", DATA1, 32'h5);
`else
        chk("mext_op", 32'(ALU_OPERATION), 32'b00010);
        chk("mext_illegal", 32'(ILLEGAL), 32'd1);
        chk("mext_data1", DATA1, 32'h0);
`endif

        // LUI, AUIPC, unsupported opcode
        put(7'h37, 3'd0, 7'h00, 32'hdead, 32'hbeef, 32'h1234_5000);
        tick(); IN_VALID = 1'b0;
        @(negedge CLK);
        chk("lui_data1", DATA1, 32'h0);
        chk("lui_data2", DATA2, 32'h1234_5000);
        chk("lui_op", 32'(ALU_OPERATION), 32'b00010);
        put(7'h17, 3'd0, 7'h00, 32'hdead, 32'hbeef, 32'h2000);
        tick(); IN_VALID = 1'b0;
        @(negedge CLK);
        chk("auipc_data1", DATA1, 32'h1000);
        put(7'h7f, 3'd0, 7'h00, 32'hdead, 32'hbeef, 32'h55);
        tick(); IN_VALID = 1'b0;
        @(negedge CLK);
        chk("bad_opc_illegal", 32'(ILLEGAL), 32'd1);
        chk("bad_opc_op", 32'(ALU_OPERATION), 32'b00010);
        chk("bad_opc_data2", DATA2, 32'h0);

        // decode sweep with intermittent back-pressure
        cyc = 0;
        for (int i = 0; i < 18; i++) begin
            put(vecs[i].opc, vecs[i].f3, vecs[i].f7, 32'h100 + i, 32'h200 + i, vecs[i].imm);
            do begin
                OUT_READY = (cyc % 3) != 0;
                tick();
                cyc++;
            end while (!acc_flag && cyc < 500);
            if (!acc_flag) chk("sweep_timeout", 32'(acc_flag), 32'd1);
        end
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        repeat (4) tick();

        // reset while stalled with two entries
        OUT_READY = 1'b0;
        put(7'h33, 3'd0, 7'h00, 32'h31, 32'h1, 32'h0);
        tick();
        put(7'h33, 3'd0, 7'h00, 32'h32, 32'h2, 32'h0);
        tick(); IN_VALID = 1'b0;
        RESET = 1'b1;
        tick(); RESET = 1'b0;
        @(negedge CLK);
        chk_reset_values("midreset");
        OUT_READY = 1'b1;
        repeat (3) tick();
        @(negedge CLK);
        chk("midreset_drop", 32'(OUT_VALID), 32'd0);

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
